// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback and
// drives datapath selects. Outputs are Moore from state + latched opcode; the
// only input-dependent terms are the FETCH/MEM handshakes, the NOP retire in
// DECODE and the branch pc_write.
module multicycle_control_unit #(
    parameter int WIDTH_OPCODE = 5,
    parameter int ALU_OP_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_OPCODE-1:0] opcode,
    input  logic                    alu_zero,
    input  logic                    mem_ready,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    reg_write,
    output logic                    instr_done,
    output logic                    illegal_op,
    output logic                    iord,
    output logic [1:0]              wb_sel,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              pc_src,
    output logic [ALU_OP_BITS-1:0]  alu_op,
    output logic [2:0]              state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [WIDTH_OPCODE-1:0] OP_NOP   = WIDTH_OPCODE'(0);
    localparam logic [WIDTH_OPCODE-1:0] OP_LR    = WIDTH_OPCODE'(1);
    localparam logic [WIDTH_OPCODE-1:0] OP_SR    = WIDTH_OPCODE'(2);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADD   = WIDTH_OPCODE'(3);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADDI  = WIDTH_OPCODE'(4);
    localparam logic [WIDTH_OPCODE-1:0] OP_SUB   = WIDTH_OPCODE'(5);
    localparam logic [WIDTH_OPCODE-1:0] OP_MOV   = WIDTH_OPCODE'(6);
    localparam logic [WIDTH_OPCODE-1:0] OP_INCR  = WIDTH_OPCODE'(7);
    localparam logic [WIDTH_OPCODE-1:0] OP_LI    = WIDTH_OPCODE'(8);
    localparam logic [WIDTH_OPCODE-1:0] OP_BEQ   = WIDTH_OPCODE'(9);
    localparam logic [WIDTH_OPCODE-1:0] OP_BNEQ  = WIDTH_OPCODE'(10);
    localparam logic [WIDTH_OPCODE-1:0] OP_BUC   = WIDTH_OPCODE'(11);
    localparam logic [WIDTH_OPCODE-1:0] OP_AND   = WIDTH_OPCODE'(12);
    localparam logic [WIDTH_OPCODE-1:0] OP_OR    = WIDTH_OPCODE'(13);
    localparam logic [WIDTH_OPCODE-1:0] OP_NOT   = WIDTH_OPCODE'(14);
    localparam logic [WIDTH_OPCODE-1:0] OP_XOR   = WIDTH_OPCODE'(15);
    localparam logic [WIDTH_OPCODE-1:0] OP_SHIFL = WIDTH_OPCODE'(16);
    localparam logic [WIDTH_OPCODE-1:0] OP_SHIFR = WIDTH_OPCODE'(17);

    localparam logic [ALU_OP_BITS-1:0] ALU_ADD    = ALU_OP_BITS'(0);
    localparam logic [ALU_OP_BITS-1:0] ALU_SUB    = ALU_OP_BITS'(1);
    localparam logic [ALU_OP_BITS-1:0] ALU_AND    = ALU_OP_BITS'(2);
    localparam logic [ALU_OP_BITS-1:0] ALU_OR     = ALU_OP_BITS'(3);
    localparam logic [ALU_OP_BITS-1:0] ALU_XOR    = ALU_OP_BITS'(4);
    localparam logic [ALU_OP_BITS-1:0] ALU_NOT    = ALU_OP_BITS'(5);
    localparam logic [ALU_OP_BITS-1:0] ALU_SHL    = ALU_OP_BITS'(6);
    localparam logic [ALU_OP_BITS-1:0] ALU_SHR    = ALU_OP_BITS'(7);
    localparam logic [ALU_OP_BITS-1:0] ALU_PASS_B = ALU_OP_BITS'(8);

    typedef struct packed {
        logic                   ir_write;
        logic                   pc_write;
        logic                   mem_req;
        logic                   mem_we;
        logic                   reg_write;
        logic                   instr_done;
        logic                   illegal_op;
        logic                   iord;
        logic [1:0]             wb_sel;
        logic                   alu_src_a;
        logic [1:0]             alu_src_b;
        logic [1:0]             pc_src;
        logic [ALU_OP_BITS-1:0] alu_op;
    } ctrl_t;

    logic [2:0]              state_q;
    logic [2:0]              next_state;
    logic [WIDTH_OPCODE-1:0] op_q;
    ctrl_t                   ctrl;

    // Opcode is captured on the DECODE->next edge so later states see a stable copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == S_DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_NOP)
                    next_state = S_FETCH;
                else if (opcode <= OP_SHIFR)
                    next_state = S_EXEC;
                else
                    next_state = S_HALT;
            end
            S_EXEC: begin
                if (op_q == OP_LR || op_q == OP_SR)
                    next_state = S_MEM;
                else if (op_q == OP_BEQ || op_q == OP_BNEQ || op_q == OP_BUC)
                    next_state = S_FETCH;
                else
                    next_state = S_WB;
            end
            S_MEM: begin
                if (mem_ready)
                    next_state = (op_q == OP_LR) ? S_WB : S_FETCH;
            end
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = 2'd1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = 2'd2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.instr_done = (opcode == OP_NOP);
            end
            S_EXEC: begin
                case (op_q)
                    OP_LR, OP_SR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 2'd2;
                    end
                    OP_ADD, OP_MOV: ctrl.alu_src_a = 1'b1;
                    OP_SUB: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_SUB;
                    end
                    OP_AND: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_AND;
                    end
                    OP_OR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_OR;
                    end
                    OP_XOR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_XOR;
                    end
                    OP_NOT: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_NOT;
                    end
                    OP_ADDI: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 2'd2;
                    end
                    OP_INCR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 2'd1;
                    end
                    OP_LI: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 2'd2;
                        ctrl.alu_op    = ALU_PASS_B;
                    end
                    OP_SHIFL: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 2'd2;
                        ctrl.alu_op    = ALU_SHL;
                    end
                    OP_SHIFR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 2'd2;
                        ctrl.alu_op    = ALU_SHR;
                    end
                    // Branch compare happens this cycle; target already sits in ALUOut.
                    OP_BEQ, OP_BNEQ: begin
                        ctrl.alu_src_a  = 1'b1;
                        ctrl.alu_op     = ALU_SUB;
                        ctrl.pc_src     = 2'd1;
                        ctrl.pc_write   = (op_q == OP_BEQ) ? alu_zero : ~alu_zero;
                        ctrl.instr_done = 1'b1;
                    end
                    OP_BUC: begin
                        ctrl.pc_src     = 2'd2;
                        ctrl.pc_write   = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.mem_we     = (op_q == OP_SR);
                ctrl.instr_done = (op_q == OP_SR) && mem_ready;
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.wb_sel     = {1'b0, op_q == OP_LR};
                ctrl.instr_done = 1'b1;
            end
            S_HALT:  ctrl.illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign reg_write  = ctrl.reg_write;
    assign instr_done = ctrl.instr_done;
    assign illegal_op = ctrl.illegal_op;
    assign iord       = ctrl.iord;
    assign wb_sel     = ctrl.wb_sel;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: each instruction is expanded into its expected per-cycle
// control trace from instruction-class rules, then replayed against the DUT.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] opcode = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, mem_req, mem_we, reg_write, instr_done, illegal_op, iord;
    logic [1:0] wb_sel, alu_src_b, pc_src;
    logic       alu_src_a;
    logic [3:0] alu_op;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_op(illegal_op), .iord(iord),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_op(alu_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_write, pc_write, mem_req, mem_we, reg_write, instr_done, illegal_op, iord;
        logic [1:0] wb_sel;
        logic       a;
        logic [1:0] b;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
    } exp_t;

    typedef struct {
        logic [4:0] op;
        logic       mr;
        logic       az;
        exp_t       e;
    } cyc_t;

    cyc_t q[$];

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = {state, ir_write, pc_write, mem_req, mem_we, reg_write, instr_done, illegal_op, iord,
             wb_sel, alu_src_a, alu_src_b, pc_src, alu_op};
        return a;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] op, input logic mr, input logic az, input exp_t e);
        cyc_t c;
        c.op = op; c.mr = mr; c.az = az; c.e = e;
        q.push_back(c);
    endtask

    // EXEC-cycle controls by instruction class.
    function automatic exp_t exec_exp(input logic [4:0] op, input logic az);
        exp_t e;
        e = blank(3'd3);
        if (op == 1 || op == 2) begin
            e.a = 1; e.b = 2;
        end else if (op == 9 || op == 10) begin
            e.a = 1; e.alu_op = 1; e.pc_src = 1; e.instr_done = 1;
            e.pc_write = (op == 9) ? az : !az;
        end else if (op == 11) begin
            e.pc_src = 2; e.pc_write = 1; e.instr_done = 1;
        end else begin
            e.a = 1;
            case (op)
                4:  e.b = 2;
                5:  e.alu_op = 1;
                7:  e.b = 1;
                8:  begin e.b = 2; e.alu_op = 8; end
                12: e.alu_op = 2;
                13: e.alu_op = 3;
                14: e.alu_op = 5;
                15: e.alu_op = 4;
                16: begin e.b = 2; e.alu_op = 6; end
                17: begin e.b = 2; e.alu_op = 7; end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Expand one instruction: fw fetch waits, mw memory waits, nhalt HALT cycles observed.
    task automatic build(input logic [4:0] op, input logic az, input int fw, input int mw, input int nhalt);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            e = blank(3'd1); e.mem_req = 1; e.b = 1;
            push(op, 1'b0, az, e);
        end
        e = blank(3'd1); e.mem_req = 1; e.b = 1; e.ir_write = 1; e.pc_write = 1;
        push(op, 1'b1, az, e);
        e = blank(3'd2); e.b = 2; e.instr_done = (op == 0);
        push(op, 1'b1, az, e);
        if (op == 0) return;
        if (op >= 18) begin
            for (int i = 0; i < nhalt; i++) begin
                e = blank(3'd6); e.illegal_op = 1;
                push(op, 1'b1, az, e);
            end
            return;
        end
        push(op, 1'b1, az, exec_exp(op, az));
        if (op >= 9 && op <= 11) return;
        if (op == 1 || op == 2) begin
            for (int i = 0; i <= mw; i++) begin
                e = blank(3'd4); e.mem_req = 1; e.iord = 1; e.mem_we = (op == 2);
                e.instr_done = (op == 2) && (i == mw);
                push(op, (i == mw), az, e);
            end
            if (op == 2) return;
        end
        e = blank(3'd5); e.reg_write = 1; e.wb_sel = (op == 1) ? 2'd1 : 2'd0; e.instr_done = 1;
        push(op, 1'b1, az, e);
    endtask

    // Replay the queued trace; exp_lat is the hand-computed retire cycle (0 = never retires).
    task automatic run(input string name, input int exp_lat);
        cyc_t c;
        int   cyc = 0, lat = 0, dn = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            opcode = c.op; mem_ready = c.mr; alu_zero = c.az;
            @(negedge clk);
            cyc++;
            chk(name, cyc, 32'(actual()), 32'(c.e));
            if (instr_done) begin dn++; lat = cyc; end
        end
        chk({name, "_done_pulses"}, cyc, 32'(dn), (exp_lat > 0) ? 32'd1 : 32'd0);
        if (exp_lat > 0) chk({name, "_latency"}, cyc, 32'(lat), 32'(exp_lat));
    endtask

    task automatic instr(input string name, input logic [4:0] op, input logic az,
                         input int fw, input int mw, input int exp_lat);
        build(op, az, fw, mw, 0);
        run(name, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_outputs", 0, 32'(actual()), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_reset_idle", 0, 32'(state), 32'd0);

        instr("add", 5'd3, 1'b0, 0, 0, 4);
        instr("lr_wait2", 5'd1, 1'b0, 0, 2, 7);
        instr("bneq_nz", 5'd10, 1'b0, 0, 0, 3);
        instr("bneq_z", 5'd10, 1'b1, 0, 0, 3);
        instr("beq_z", 5'd9, 1'b1, 0, 0, 3);
        instr("beq_nz_fw1", 5'd9, 1'b0, 1, 0, 4);
        instr("buc", 5'd11, 1'b0, 0, 0, 3);
        instr("sr", 5'd2, 1'b0, 0, 0, 4);
        instr("sr_wait1", 5'd2, 1'b1, 0, 1, 5);
        instr("nop", 5'd0, 1'b0, 0, 0, 2);
        instr("sub", 5'd5, 1'b0, 0, 0, 4);
        instr("and", 5'd12, 1'b1, 0, 0, 4);
        instr("or", 5'd13, 1'b0, 0, 0, 4);
        instr("xor", 5'd15, 1'b0, 0, 0, 4);
        instr("not", 5'd14, 1'b0, 0, 0, 4);
        instr("mov", 5'd6, 1'b0, 0, 0, 4);
        instr("addi", 5'd4, 1'b0, 0, 0, 4);
        instr("incr", 5'd7, 1'b0, 2, 0, 6);
        instr("li", 5'd8, 1'b0, 0, 0, 4);
        instr("shifl", 5'd16, 1'b0, 0, 0, 4);
        instr("shifr", 5'd17, 1'b0, 0, 0, 4);
        instr("lr", 5'd1, 1'b0, 0, 0, 5);

        // Asynchronous reset landing in the middle of a stalled fetch.
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("midfetch_state", 0, 32'(state), 32'd1);
        chk("midfetch_mem_req", 0, 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mem_req", 0, 32'(mem_req), 32'd0);
        chk("rst_state", 0, 32'(state), 32'd0);
        mem_ready = 1'b1;
        #1 chk("rst_ir_write", 0, 32'(ir_write), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        build(5'd18, 1'b0, 0, 0, 5);
        run("halt18", 0);
        #2 rst_n = 1'b0;
        #1 chk("halt18_rst_illegal", 0, 32'(illegal_op), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        build(5'd31, 1'b0, 0, 0, 20);
        run("halt31", 0);
        #2 rst_n = 1'b0;
        #1 chk("halt31_rst_illegal", 0, 32'(illegal_op), 32'd0);
        chk("halt31_rst_state", 0, 32'(state), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        instr("add_after_halt", 5'd3, 1'b0, 0, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter WIDTH_OPCODE, default 5, the opcode field width.
REQ-002 The block SHALL have parameter ALU_OP_BITS, default 4, the alu_op width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port opcode, input, WIDTH_OPCODE, instruction[28:24] from the decoder, valid from DECODE onward.
REQ-006 The block SHALL have port alu_zero, input, 1, ALU result==0, sampled in EXEC of a branch.
REQ-007 The block SHALL have port mem_ready, input, 1, memory completes the current mem_req this cycle.
REQ-008 The block SHALL have ports ir_write, pc_write, mem_req, mem_we, reg_write, instr_done, illegal_op, outputs, 1 bit each.
REQ-009 The block SHALL have ports iord (0=PC, 1=ALUOut address), wb_sel[1:0] (0=ALUOut, 1=MDR), alu_src_a (0=PC, 1=Rs), alu_src_b[1:0] (0=Rt, 1=const 1, 2=sign-extended immed), pc_src[1:0] (0=ALU, 1=ALUOut, 2=jump immed[23:0]), all outputs.
REQ-010 The block SHALL have port alu_op, output, ALU_OP_BITS: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 PASS_B.
REQ-011 The block SHALL have port state, output, 3, current state encoding for debug.

Function
REQ-012 The FSM SHALL have states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; all outputs SHALL be Moore-decoded from state plus registered opcode, except where stated.
REQ-013 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-014 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0; stay while mem_ready=0; in the cycle mem_ready=1, assert ir_write=1 and pc_write=1, then go to DECODE.
REQ-015 DECODE: latch opcode internally; alu_src_a=0, alu_src_b=2, alu_op=ADD (branch target into ALUOut); next: opcode 0 (NOP) -> FETCH with instr_done=1; opcodes 1-17 -> EXEC; opcodes 18-31 -> HALT.
REQ-016 EXEC for lr(1)/sr(2): alu_src_a=1, alu_src_b=2, ADD; -> MEM.
REQ-017 EXEC for add(3)/sub(5)/and(12)/or(13)/xor(15): alu_src_a=1, alu_src_b=0, op ADD/SUB/AND/OR/XOR; not(14)->NOT, mov(6)->ADD with alu_src_b=0 (Rt field is R0); addi(4)->ADD with alu_src_b=2; incr(7)->ADD with alu_src_b=1; li(8)->PASS_B with alu_src_b=2; shifl(16)/shifr(17)->SHL/SHR with alu_src_b=2; all -> WB.
REQ-018 EXEC for beq(9)/bneq(10): alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_write=alu_zero for beq, ~alu_zero for bneq (combinational on alu_zero); instr_done=1; -> FETCH.
REQ-019 EXEC for buc(11): pc_src=2, pc_write=1, instr_done=1; -> FETCH.
REQ-020 MEM: mem_req=1, iord=1, mem_we=1 only for sr; hold all outputs while mem_ready=0; on mem_ready=1: lr -> WB, sr -> FETCH with instr_done=1.
REQ-021 WB: reg_write=1, wb_sel=1 for lr else 0; instr_done=1; -> FETCH.
REQ-022 HALT: illegal_op=1, all other outputs 0; remain in HALT until reset.
REQ-023 Latency with mem_ready tied 1 SHALL be: NOP 2 cycles, beq/bneq/buc 3, sr 4, ALU/li/mov 4, lr 5; each mem wait cycle adds exactly 1.
REQ-024 pc_write, ir_write, reg_write and mem_we SHALL never be asserted in the same cycle as another of these except pc_write with ir_write in FETCH.
REQ-025 instr_done SHALL pulse exactly one cycle per retired instruction.

Reset
REQ-026 rst_n=0 SHALL force state=IDLE and every output to 0 immediately, independent of clk, including mid-FETCH/MEM with mem_req high.
REQ-027 After rst_n deasserts, first rising edge SHALL move IDLE->FETCH; HALT exits only by reset.

Verification
REQ-028 mem_ready=1, opcode=3 -> states 1,2,3,5,1; reg_write=1 only in WB; alu_op=0 in EXEC; instr_done one pulse.
REQ-029 opcode=1, mem_ready low 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, iord=1, mem_we=0; WB wb_sel=1; total 7 cycles.
REQ-030 opcode=10, alu_zero=0 -> pc_write=1, pc_src=1 in EXEC; repeat alu_zero=1 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-031 opcode=0x1F -> DECODE then HALT, illegal_op=1 held 20 cycles; rst_n pulse -> illegal_op=0, state=IDLE.
REQ-032 rst_n asserted mid-FETCH while mem_req=1 and mem_ready=0 -> mem_req drops same cycle, state=0, no ir_write.
REQ-033 opcode=2, mem_ready=1 -> mem_we=1 exactly one cycle in MEM, reg_write never 1, 4-cycle instruction.
